ahb_lite_mem_slave: RTL and testbench

Parametrised AHB3-Lite memory slave, generalising the current single-configuration slave.
- Configurable data width, memory depth and wait-state count.
- Byte-lane writes per HSIZE, plus an optional zero-wait mode for sequential burst beats.
- Protocol-correct two-cycle ERROR responses.
- Sits behind the AHB decoder and is driven by the existing ahb_if master and bench; HREADY is looped back from HREADYOUT at the top level.

---
 rtl/ahb_lite_mem_slave_pkg.sv | 25 ++
 rtl/ahb_lite_mem_slave_if.sv | 32 +++
 rtl/ahb_lite_byte_en.sv | 23 ++
 rtl/ahb_lite_mem_slave.sv | 139 +++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared AHB3-Lite types and constants for the memory slave and its bus interface.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  // log2 of the transfer size in bytes
  typedef logic [2:0] hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slave_state_t;

endpackage

// File: rtl/ahb_lite_mem_slave_if.sv
// AHB3-Lite bus bundle between a master (or decoder) and one slave.
interface ahb_if
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  hsize_t            HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_lite_byte_en.sv
// Byte-lane enables for one transfer: a lane is active when it lies in the same
// 2^size-byte block as the address. Sizes at or above the bus width select all lanes.
module ahb_lite_byte_en
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] addr_i,
  input  hsize_t                      size_i,
  output logic [DATA_W/8-1:0]         be_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  // Compare block indices of each lane and of the address at the transfer size
  always_comb begin
    be_o = '0;
    for (int unsigned i = 0; i < StrbW; i++) begin
      be_o[i] = ((i >> size_i) == (32'(addr_i) >> size_i));
    end
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// Parametrised AHB3-Lite memory slave with configurable wait states, byte-lane
// writes, optional zero-wait SEQ beats and two-cycle ERROR responses.
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned MEM_DEPTH     = 1024,
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned SEQ_ZERO_WAIT = 1
) (
  input logic   HCLK,
  input logic   HRESETn,
  ahb_if.slave  bus
);

  localparam int unsigned     StrbW    = DATA_W / 8;
  localparam int unsigned     LaneW    = $clog2(StrbW);
  localparam int unsigned     IdxW     = $clog2(MEM_DEPTH);
  localparam longint unsigned MemBytes = 64'(MEM_DEPTH) * 64'(StrbW);

  slave_state_t      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  hsize_t            size_q;
  logic [1:0]        trans_q;

  logic              accept;
  logic              take;
  logic              acc_err;
  logic [3:0]        acc_waits;
  logic [ADDR_W-1:0] align_mask;
  logic              hreadyout;
  logic              hresp;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [StrbW-1:0]  be;
  logic [IdxW-1:0]   word_idx;
  logic              commit;

  assign accept     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign align_mask = (ADDR_W'(1) << bus.HSIZE) - ADDR_W'(1);
  assign acc_err    = (64'(bus.HADDR) >= MemBytes) ||
                      (bus.HSIZE > 3'(LaneW)) ||
                      ((bus.HADDR & align_mask) != '0);
  assign acc_waits  = ((SEQ_ZERO_WAIT != 0) && (bus.HTRANS == SEQ)) ? 4'd0 : 4'(WAIT_STATES);

  // Next-state and response outputs; an accept is only honoured when the bus is ready
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    take      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (state_q == S_ERR2) hresp = HRESP_ERROR;
        if (accept) begin
          take = 1'b1;
          if (acc_err) begin
            state_d = S_ERR1;
          end else if (acc_waits == 4'd0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = acc_waits - 4'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, wait counter and address-phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      trans_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        addr_q  <= bus.HADDR;
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
        trans_q <= bus.HTRANS;
      end
    end
  end

  ahb_lite_byte_en #(
    .DATA_W (DATA_W)
  ) u_byte_en (
    .addr_i (addr_q[LaneW-1:0]),
    .size_i (size_q),
    .be_o   (be)
  );

  assign word_idx = addr_q[IdxW+LaneW-1:LaneW];
  assign commit   = (state_q == S_DATA) && write_q;

  // Write commit at the edge closing the data phase; array is intentionally not reset
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[word_idx] : '0;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;

  // Burst type, protection and the captured trans type do not affect behaviour
  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HPROT, addr_q, trans_q};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench for ahb_lite_mem_slave: one zero-wait instance and one with two
// wait states, sharing a single master driver selected by tgt.
module tb_ahb_lite_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  bit          tgt;

  logic        hready_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;

  int          n_checks;
  int          n_errors;

  logic [31:0] rd;
  int          low;
  logic        r1;
  logic        r0;
  logic [31:0] brd [4];

  ahb_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  ahb_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

  assign bus0.HSEL   = hsel & ~tgt;
  assign bus0.HADDR  = haddr;
  assign bus0.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;
  assign bus0.HSIZE  = hsize;
  assign bus0.HBURST = hburst;
  assign bus0.HPROT  = 4'b0011;
  assign bus0.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus2.HSEL   = hsel & tgt;
  assign bus2.HADDR  = haddr;
  assign bus2.HTRANS = htrans;
  assign bus2.HWRITE = hwrite;
  assign bus2.HSIZE  = hsize;
  assign bus2.HBURST = hburst;
  assign bus2.HPROT  = 4'b0011;
  assign bus2.HWDATA = hwdata;
  assign bus2.HREADY = bus2.HREADYOUT;

  assign hready_o = tgt ? bus2.HREADYOUT : bus0.HREADYOUT;
  assign hresp_o  = tgt ? bus2.HRESP     : bus0.HRESP;
  assign hrdata_o = tgt ? bus2.HRDATA    : bus0.HRDATA;

  ahb_lite_mem_slave #(
    .DATA_W        (32),
    .ADDR_W        (32),
    .MEM_DEPTH     (1024),
    .WAIT_STATES   (0),
    .SEQ_ZERO_WAIT (1)
  ) u_dut0 (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus0)
  );

  ahb_lite_mem_slave #(
    .DATA_W        (32),
    .ADDR_W        (32),
    .MEM_DEPTH     (1024),
    .WAIT_STATES   (2),
    .SEQ_ZERO_WAIT (1)
  ) u_dut2 (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // Single NONSEQ transfer; reports data, wait count and HRESP of first/last data cycle
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                      output logic resp_first, output logic resp_last);
    @(posedge clk); #1;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    @(posedge clk); #1;
    hsel       = 1'b0;
    htrans     = 2'b00;
    hwdata     = wdata;
    waits      = 0;
    resp_first = hresp_o;
    while (!hready_o && waits < 20) begin
      waits++;
      @(posedge clk); #1;
    end
    rdata     = hrdata_o;
    resp_last = hresp_o;
  endtask

  // INCR4 read: NONSEQ then three SEQ beats, pipelined; counts HREADYOUT-low cycles
  task automatic burst_read(input logic [31:0] base, output int waits);
    int   issued;
    int   got;
    int   cyc;
    logic rdy_prev;
    @(posedge clk); #1;
    hsel     = 1'b1;
    htrans   = 2'b10;
    haddr    = base;
    hwrite   = 1'b0;
    hsize    = 3'd2;
    hburst   = 3'b011;
    issued   = 1;
    got      = 0;
    cyc      = 0;
    waits    = 0;
    rdy_prev = 1'b1;
    while (got < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy_prev) begin
        if (issued < 4) begin
          haddr  = base + 32'(4 * issued);
          htrans = 2'b11;
          issued++;
        end else begin
          hsel   = 1'b0;
          htrans = 2'b00;
        end
      end
      if (!hready_o) begin
        waits++;
      end else begin
        brd[got] = hrdata_o;
        got++;
      end
      rdy_prev = hready_o;
    end
    check_eq("burst_done", 32'(got), 32'd4);
    hsel   = 1'b0;
    htrans = 2'b00;
    hburst = 3'b000;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    tgt      = 1'b0;
    hsel     = 1'b0;
    haddr    = '0;
    htrans   = 2'b00;
    hwrite   = 1'b0;
    hsize    = 3'd2;
    hburst   = 3'b000;
    hwdata   = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready0", 32'(hready_o), 32'd1);
    check_eq("rst_resp0", 32'(hresp_o), 32'd0);
    check_eq("rst_rdata0", hrdata_o, 32'h0);
    tgt = 1'b1;
    #1;
    check_eq("rst_ready2", 32'(hready_o), 32'd1);
    check_eq("rst_resp2", 32'(hresp_o), 32'd0);
    tgt   = 1'b0;
    rst_n = 1'b1;

    // IDLE and BUSY with HSEL high are not transfers
    @(posedge clk); #1;
    hsel   = 1'b1;
    htrans = 2'b00;
    @(posedge clk); #1;
    check_eq("idle_ready", 32'(hready_o), 32'd1);
    check_eq("idle_resp", 32'(hresp_o), 32'd0);
    htrans = 2'b01;
    @(posedge clk); #1;
    check_eq("busy_ready", 32'(hready_o), 32'd1);
    check_eq("busy_rdata", hrdata_o, 32'h0);
    hsel   = 1'b0;
    htrans = 2'b00;

    // Zero-wait word write and read-back
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, low, r1, r0);
    check_eq("wr10_waits", 32'(low), 32'd0);
    check_eq("wr10_resp", 32'(r0), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("rd10_waits", 32'(low), 32'd0);
    check_eq("rd10_data", rd, 32'hDEADBEEF);

    // Byte and halfword lanes
    xfer(1'b1, 32'h20, 3'd2, 32'hAABBCCDD, rd, low, r1, r0);
    xfer(1'b1, 32'h22, 3'd0, 32'h00110000, rd, low, r1, r0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("byte22", rd, 32'hAA11CCDD);
    xfer(1'b1, 32'h21, 3'd0, 32'h0000EE00, rd, low, r1, r0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("byte21", rd, 32'hAA11EEDD);
    xfer(1'b1, 32'h22, 3'd1, 32'h55660000, rd, low, r1, r0);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("half22", rd, 32'h5566EEDD);

    // Out-of-range read: one low ERROR cycle, then ERROR with ready
    xfer(1'b0, 32'h1000, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("oob_waits", 32'(low), 32'd1);
    check_eq("oob_resp1", 32'(r1), 32'd1);
    check_eq("oob_resp2", 32'(r0), 32'd1);
    check_eq("oob_rdata", rd, 32'h0);
    xfer(1'b0, 32'hFFC, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("top_word_resp", 32'(r0), 32'd0);

    // Misaligned halfword write must not touch memory
    xfer(1'b1, 32'h21, 3'd1, 32'hFFFFFFFF, rd, low, r1, r0);
    check_eq("mis_waits", 32'(low), 32'd1);
    check_eq("mis_resp1", 32'(r1), 32'd1);
    check_eq("mis_resp2", 32'(r0), 32'd1);
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("mis_nochange", rd, 32'h5566EEDD);
    check_eq("mis_after_resp", 32'(r0), 32'd0);

    // Oversized transfer
    xfer(1'b1, 32'h40, 3'd3, 32'h12121212, rd, low, r1, r0);
    check_eq("size_resp", 32'(r0), 32'd1);
    check_eq("size_waits", 32'(low), 32'd1);

    // Two-wait instance
    tgt = 1'b1;
    xfer(1'b1, 32'h100, 3'd2, 32'h01010101, rd, low, r1, r0);
    check_eq("ws_wr_waits", 32'(low), 32'd2);
    xfer(1'b1, 32'h104, 3'd2, 32'h02020202, rd, low, r1, r0);
    xfer(1'b1, 32'h108, 3'd2, 32'h03030303, rd, low, r1, r0);
    xfer(1'b1, 32'h10C, 3'd2, 32'h04040404, rd, low, r1, r0);
    xfer(1'b0, 32'h104, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("ws_rd_waits", 32'(low), 32'd2);
    check_eq("ws_rd_resp", 32'(r1), 32'd0);
    check_eq("ws_rd_data", rd, 32'h02020202);

    burst_read(32'h100, low);
    check_eq("burst_waits", 32'(low), 32'd2);
    check_eq("burst_d0", brd[0], 32'h01010101);
    check_eq("burst_d1", brd[1], 32'h02020202);
    check_eq("burst_d2", brd[2], 32'h03030303);
    check_eq("burst_d3", brd[3], 32'h04040404);

    // Reset during the wait phase of a write abandons it
    xfer(1'b1, 32'h30, 3'd2, 32'h12345678, rd, low, r1, r0);
    @(posedge clk); #1;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h30;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge clk); #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'hCAFEF00D;
    check_eq("rstw_inwait", 32'(hready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rstw_ready", 32'(hready_o), 32'd1);
    check_eq("rstw_resp", 32'(hresp_o), 32'd0);
    check_eq("rstw_rdata", hrdata_o, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, low, r1, r0);
    check_eq("rstw_old", rd, 32'h12345678);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
